// File: rtl/isa_pkg.sv
// Shared ISA constants for fetch, forwarding and the LM/SM sequencer.
// Opcodes, NOP encoding, instruction field positions and the sequencer state type.
package isa_pkg;

  localparam logic [3:0] OpLw = 4'b0100;
  localparam logic [3:0] OpSw = 4'b0101;
  localparam logic [3:0] OpLm = 4'b0110;
  localparam logic [3:0] OpSm = 4'b0111;

  // Opcode 1011 is unused by the ISA, so it doubles as a NOP.
  localparam logic [15:0] NopIr = 16'hB000;

  localparam int unsigned OpMsb   = 15;
  localparam int unsigned OpLsb   = 12;
  localparam int unsigned RaMsb   = 11;
  localparam int unsigned RaLsb   = 9;
  localparam int unsigned ListMsb = 7;
  localparam int unsigned ListLsb = 0;

  typedef enum logic [0:0] {StIdle, StSeq} seq_state_e;

  // Number of set bits in mask strictly below position idx.
  function automatic logic [2:0] rank_below(input logic [7:0] mask, input logic [2:0] idx);
    logic [2:0] cnt;
    cnt = '0;
    for (int j = 0; j < 7; j++) begin
      if (j < int'(idx) && mask[j]) cnt = cnt + 3'd1;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/lowest_set8.sv
// Lowest-set-bit encoder over an 8-bit register list with one optionally excluded index.
// The excluded bit is only reported once it is the sole remaining bit.
module lowest_set8
  import isa_pkg::*;
(
  input  logic [7:0] mask_i,
  input  logic [2:0] excl_idx_i,
  input  logic       excl_en_i,
  output logic [2:0] idx_o,
  output logic [2:0] rank_o,
  output logic       valid_o
);

  logic [7:0] excl_bit;
  logic [7:0] eff_mask;
  logic [7:0] pick_mask;

  always_comb begin
    excl_bit  = excl_en_i ? (8'b1 << excl_idx_i) : 8'b0;
    eff_mask  = mask_i & ~excl_bit;
    pick_mask = (eff_mask != 8'b0) ? eff_mask : mask_i;
    idx_o     = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pick_mask[i]) idx_o = 3'(i);
    end
    rank_o  = rank_below(mask_i, idx_o);
    valid_o = (mask_i != 8'b0);
  end

endmodule

// File: rtl/lm_sm_sequencer.sv
// Expands LM/SM leaving fetch into one LW/SW micro-op per cycle, holding the PC until
// the last one issues. The first micro-op is combinational from IR_in.
module lm_sm_sequencer
  import isa_pkg::*;
#(
  parameter logic [15:0] NOP_IR = NopIr
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] IR_in,
  input  logic        IR_valid,
  input  logic        stall_in,
  input  logic        flush,
  output logic [15:0] new_IR_multi,
  output logic        IR_load_mux,
  output logic        PCWrite,
  output logic        busy
);

  seq_state_e state_q, state_d;
  logic [7:0] mask_q, mask_d;
  logic [2:0] ra_q, ra_d;
  logic       is_lm_q, is_lm_d;
  logic [2:0] rank_q, rank_d;
  logic       defer_q, defer_d;
  logic [2:0] defer_rank_q, defer_rank_d;

  logic [3:0]  ir_op;
  logic [2:0]  ir_ra;
  logic [7:0]  ir_list;
  logic        ir_is_lm, ir_is_multi, unused_ir_bit;
  logic        in_seq, detect, sole, uop_is_lm;
  logic [7:0]  sel_mask, clear_bit;
  logic [2:0]  sel_ra, uop_k, lo_idx, lo_rank;
  logic        sel_excl, lo_valid;
  logic [15:0] uop;

  assign ir_op         = IR_in[OpMsb:OpLsb];
  assign ir_ra         = IR_in[RaMsb:RaLsb];
  assign ir_list       = IR_in[ListMsb:ListLsb];
  assign unused_ir_bit = IR_in[8];
  assign ir_is_lm      = (ir_op == OpLm);
  assign ir_is_multi   = ir_is_lm || (ir_op == OpSm);
  assign in_seq        = (state_q == StSeq);

  // In IDLE the encoder looks at the incoming list, in SEQ at the registered remainder.
  assign sel_mask  = in_seq ? mask_q : ir_list;
  assign sel_ra    = in_seq ? ra_q : ir_ra;
  assign sel_excl  = in_seq ? defer_q : (ir_is_lm && ir_list[ir_ra]);
  assign uop_is_lm = in_seq ? is_lm_q : ir_is_lm;

  lowest_set8 u_lowest_set8 (
    .mask_i    (sel_mask),
    .excl_idx_i(sel_ra),
    .excl_en_i (sel_excl),
    .idx_o     (lo_idx),
    .rank_o    (lo_rank),
    .valid_o   (lo_valid)
  );

  always_comb begin
    sole      = ((sel_mask & (sel_mask - 8'd1)) == 8'd0);
    clear_bit = 8'b1 << lo_idx;
    // Only a pending deferred base can sit below the current pick in SEQ.
    if (!in_seq) begin
      uop_k = lo_rank;
    end else if (defer_q && lo_idx == ra_q) begin
      uop_k = defer_rank_q;
    end else begin
      uop_k = rank_q + lo_rank;
    end
    uop = {(uop_is_lm ? OpLw : OpSw), lo_idx, sel_ra, 3'b000, uop_k};
  end

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    ra_d         = ra_q;
    is_lm_d      = is_lm_q;
    rank_d       = rank_q;
    defer_d      = defer_q;
    defer_rank_d = defer_rank_q;
    new_IR_multi = NOP_IR;
    IR_load_mux  = 1'b0;
    PCWrite      = 1'b1;
    detect       = 1'b0;

    unique case (state_q)
      StIdle: begin
        detect = IR_valid && ir_is_multi && !flush && !stall_in;
        if (detect) begin
          IR_load_mux = 1'b1;
          if (lo_valid) begin
            new_IR_multi = uop;
            if (!sole) begin
              PCWrite      = 1'b0;
              state_d      = StSeq;
              mask_d       = ir_list & ~clear_bit;
              ra_d         = ir_ra;
              is_lm_d      = ir_is_lm;
              rank_d       = 3'd1;
              defer_d      = sel_excl;
              defer_rank_d = rank_below(ir_list, ir_ra);
            end
          end
        end
      end
      StSeq: begin
        IR_load_mux  = 1'b1;
        new_IR_multi = uop;
        PCWrite      = !stall_in && sole;
        if (!stall_in) begin
          mask_d = mask_q & ~clear_bit;
          if (rank_q != 3'd7) rank_d = rank_q + 3'd1;
          if (lo_idx == ra_q) defer_d = 1'b0;
          if (sole) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (flush) begin
      state_d = StIdle;
      mask_d  = 8'b0;
      defer_d = 1'b0;
    end
  end

  assign busy = in_seq;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      mask_q       <= 8'b0;
      ra_q         <= 3'd0;
      is_lm_q      <= 1'b0;
      rank_q       <= 3'd0;
      defer_q      <= 1'b0;
      defer_rank_q <= 3'd0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      ra_q         <= ra_d;
      is_lm_q      <= is_lm_d;
      rank_q       <= rank_d;
      defer_q      <= defer_d;
      defer_rank_q <= defer_rank_d;
    end
  end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Directed bench for lm_sm_sequencer: hand-computed micro-op streams for LM/SM expansion,
// base deferral, empty list, stall, flush and reset abort.
module tb_lm_sm_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] IR_in;
  logic        IR_valid, stall_in, flush;
  logic [15:0] new_IR_multi;
  logic        IR_load_mux, PCWrite, busy;

  int n_vec = 0;
  int n_err = 0;

  lm_sm_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .IR_in       (IR_in),
    .IR_valid    (IR_valid),
    .stall_in    (stall_in),
    .flush       (flush),
    .new_IR_multi(new_IR_multi),
    .IR_load_mux (IR_load_mux),
    .PCWrite     (PCWrite),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs are driven 1 time unit after posedge; outputs are checked mid-cycle.
  task automatic chk_out(input string tag, input logic [15:0] e_ir, input logic e_load,
                         input logic e_pc, input logic e_busy);
    #3;
    check_eq({tag, ".ir"}, new_IR_multi, e_ir);
    check_eq({tag, ".load"}, {15'b0, IR_load_mux}, {15'b0, e_load});
    check_eq({tag, ".pcw"}, {15'b0, PCWrite}, {15'b0, e_pc});
    check_eq({tag, ".busy"}, {15'b0, busy}, {15'b0, e_busy});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; IR_in = 16'h0000; IR_valid = 1'b0; stall_in = 1'b0; flush = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
    chk_out("reset", 16'hB000, 1'b0, 1'b1, 1'b0);

    // LM R2, list 0000_0101
    cyc(); IR_in = 16'h6405; IR_valid = 1'b1;
    chk_out("lm2.n0", 16'h4080, 1'b1, 1'b0, 1'b0);
    cyc(); IR_valid = 1'b0;
    chk_out("lm2.n1", 16'h4481, 1'b1, 1'b1, 1'b1);
    cyc();
    chk_out("lm2.idle", 16'hB000, 1'b0, 1'b1, 1'b0);

    // SM R1, list FF
    cyc(); IR_in = 16'h72FF; IR_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk_out($sformatf("smff.%0d", i), 16'h5040 | 16'(i << 9) | 16'(i),
              1'b1, (i == 7), (i != 0));
      cyc(); IR_valid = 1'b0;
    end
    chk_out("smff.idle", 16'hB000, 1'b0, 1'b1, 1'b0);

    // LM R3, list 0010_1000: base deferred to the end with its original rank
    cyc(); IR_in = 16'h6628; IR_valid = 1'b1;
    chk_out("defer.n0", 16'h4AC1, 1'b1, 1'b0, 1'b0);
    cyc(); IR_valid = 1'b0;
    chk_out("defer.n1", 16'h46C0, 1'b1, 1'b1, 1'b1);
    cyc();
    chk_out("defer.idle", 16'hB000, 1'b0, 1'b1, 1'b0);

    // LM empty list
    cyc(); IR_in = 16'h6400; IR_valid = 1'b1;
    chk_out("empty.n0", 16'hB000, 1'b1, 1'b1, 1'b0);
    cyc(); IR_valid = 1'b0;
    chk_out("empty.n1", 16'hB000, 1'b0, 1'b1, 1'b0);

    // SM R0, list 07 with two stall cycles after the first micro-op
    cyc(); IR_in = 16'h7007; IR_valid = 1'b1;
    chk_out("stall.n0", 16'h5000, 1'b1, 1'b0, 1'b0);
    cyc(); IR_valid = 1'b0; stall_in = 1'b1;
    chk_out("stall.n1", 16'h5201, 1'b1, 1'b0, 1'b1);
    cyc();
    chk_out("stall.n2", 16'h5201, 1'b1, 1'b0, 1'b1);
    cyc(); stall_in = 1'b0;
    chk_out("stall.n3", 16'h5201, 1'b1, 1'b0, 1'b1);
    cyc();
    chk_out("stall.n4", 16'h5402, 1'b1, 1'b1, 1'b1);
    cyc();
    chk_out("stall.idle", 16'hB000, 1'b0, 1'b1, 1'b0);

    // LM R1, list F0, flushed on the 2nd cycle
    cyc(); IR_in = 16'h62F0; IR_valid = 1'b1;
    chk_out("flush.n0", 16'h4840, 1'b1, 1'b0, 1'b0);
    cyc(); IR_valid = 1'b0; flush = 1'b1;
    chk_out("flush.n1", 16'h4A41, 1'b1, 1'b0, 1'b1);
    cyc(); flush = 1'b0;
    chk_out("flush.idle", 16'hB000, 1'b0, 1'b1, 1'b0);

    // Same sequence, reset on the 3rd cycle
    cyc(); IR_valid = 1'b1;
    chk_out("rst.n0", 16'h4840, 1'b1, 1'b0, 1'b0);
    cyc(); IR_valid = 1'b0;
    chk_out("rst.n1", 16'h4A41, 1'b1, 1'b0, 1'b1);
    cyc(); reset = 1'b0;
    chk_out("rst.n2", 16'h4C42, 1'b1, 1'b0, 1'b1);
    cyc(); reset = 1'b1;
    chk_out("rst.idle", 16'hB000, 1'b0, 1'b1, 1'b0);

    // Flush and stall both suppress detection in IDLE
    cyc(); IR_valid = 1'b1; flush = 1'b1;
    chk_out("idle.flush", 16'hB000, 1'b0, 1'b1, 1'b0);
    cyc(); flush = 1'b0; stall_in = 1'b1;
    chk_out("idle.stall", 16'hB000, 1'b0, 1'b1, 1'b0);
    cyc();
    chk_out("idle.stall2", 16'hB000, 1'b0, 1'b1, 1'b0);
    cyc(); stall_in = 1'b0; IR_valid = 1'b0;

    // Non-LM/SM instruction is ignored
    IR_in = 16'h40FF; IR_valid = 1'b1;
    chk_out("other", 16'hB000, 1'b0, 1'b1, 1'b0);
    cyc(); IR_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lm_sm_sequencer.md
# lm_sm_sequencer

Multi-cycle expander for LM/SM. It sits beside the fetch stage and watches the instruction leaving fetch. When it sees LM or SM, it replaces that instruction with a sequence of single-register LW/SW micro-ops, one per cycle. Micro-ops go to fetch on `new_IR_multi` and are selected by `IR_load_mux`. `PCWrite` is held low until the last micro-op issues, so fetch does not advance past the LM/SM.

## Interface
Parameters:
- `NOP_IR`, 16'hB000: opcode 1011 is unused; this value is emitted for an empty register list.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-low.
- `IR_in`  in  16  instruction currently leaving fetch: [15:12] opcode, [11:9] base RA, [7:0] register list.
- `IR_valid`  in  1  `IR_in` is a real instruction, not a bubble.
- `stall_in`  in  1  downstream hazard stall; the sequencer must hold.
- `flush`  in  1  branch/jump redirect; abort any sequence.
- `new_IR_multi`  out  16  current micro-op.
- `IR_load_mux`  out  1  1 selects `new_IR_multi` over instruction memory.
- `PCWrite`  out  1  0 holds the PC register.
- `busy`  out  1  state is SEQ.

## Operation
- **Micro-op format:** `{op, Ri, RA, k[5:0]}`.
  - `op` is LW (0100) for LM and SW (0101) for SM.
  - `Ri` is the register index of a set list bit.
  - `k` is the rank of bit i among the set bits in ascending index order.
  - Memory address is therefore RA+k, which matches consecutive-address LM/SM semantics.
- **Issue order:**
  - Micro-ops issue in ascending i.
  - Exception, LM only: if list bit RA is set, the RA micro-op is deferred to the end. It keeps its original rank k. This prevents the base being overwritten mid-sequence.
  - SM never defers.
- **States:** IDLE and SEQ. Registered state holds: remaining mask (8), base RA (3), is_LM (1), next rank (3), defer flag (1).
- **IDLE, detect condition:** `IR_valid=1`, opcode is LM or SM, `flush=0`.
  - Outputs combinationally in the same cycle: `IR_load_mux=1`; `new_IR_multi` = first micro-op from the lowest-set-bit encode of `IR_in`.
  - If popcount > 1: `PCWrite=0`. Remaining mask is latched minus the emitted bit. Go to SEQ.
  - If popcount = 1: `PCWrite=1`. Stay IDLE.
  - If the list is empty: `new_IR_multi=NOP_IR`, `PCWrite=1`. Stay IDLE.
- **SEQ:** each cycle with `stall_in=0` emits the next micro-op from registers and clears its mask bit. `IR_load_mux=1`.
  - `PCWrite=0`, except `PCWrite=1` on the cycle emitting the final micro-op.
  - The following cycle is IDLE.
- **Stall:** `stall_in=1` in SEQ freezes all state. Outputs repeat the same micro-op with `PCWrite=0`. In IDLE, stall suppresses detection.
- **Flush:** takes priority over stall and detect. Next cycle is IDLE with the mask cleared.
- **Idle outputs:** `IR_load_mux=0`, `new_IR_multi=NOP_IR`, `PCWrite=1`, `busy=0`.

## Timing
- Reset (`reset=0` at posedge) wins over everything. The cycle after reset shows idle outputs.
- A list with n ≥ 1 set bits occupies cycles N .. N+n-1 when unstalled. `PCWrite` is low for cycles N .. N+n-2.
- Each stalled cycle adds exactly one cycle. There are no bubbles between micro-ops.
- The first micro-op has zero latency (combinational from `IR_in`). All later micro-ops come from registers.
- Reset or flush mid-sequence discards the remaining micro-ops. No partial micro-op is re-emitted.
- Maximum sequence length is 8 cycles. The rank counter saturates at 7, so no wrap-around.

## Structure
- **Shared package `isa_pkg`:** opcodes LW, SW, LM, SM; `NOP_IR`; field-slice constants; the state enum {IDLE, SEQ}. The fetch and forwarding logic reuses the same opcode constants.
- **Sub-module `lowest_set8`:**
  - Input: 8-bit mask plus an excluded index (RA when LM, none for SM).
  - Output: lowest set index (3 bits), its rank (3 bits), valid.
  - The excluded bit is reported only when it is the sole remaining bit.

## Test plan
- LM base R2, list 8'b0000_0101 → cycle N: `16'h4080`, `PCWrite=0`; N+1: `16'h4481`, `PCWrite=1`; N+2: idle, `IR_load_mux=0`.
- SM base R1, list 8'hFF → eight micro-ops `16'h5040`, `16'h5241`, …, `16'h5E47`; `PCWrite` low for 7 cycles, high on the 8th.
- LM base R3, list 8'b0010_1000 (base deferral) → `16'h4AC1` (R5, k=1), then `16'h46C0` (R3, k=0).
- LM, list 8'h00 → one cycle of `16'hB000` with `IR_load_mux=1`, `PCWrite=1`, `busy` stays 0.
- SM, list 8'h07, `stall_in=1` for 2 cycles after the first micro-op → the second micro-op is held 3 cycles with `PCWrite=0`; the sequence then completes and ends in total 5 cycles after N.
- LM, list 8'hF0: `flush=1` on the 2nd cycle → idle next cycle. Repeat with `reset=0` on the 3rd cycle → idle next cycle, `PCWrite=1`.
